// File: rtl/joypad_serializer.sv
// Emulates NUM_PORTS serial joypads on the NES latch/clock/data pins, loading
// parallel button words from GPIO with input synchronisers and per-button turbo.
module joypad_serializer #(
    parameter int   NUM_PORTS    = 2,
    parameter int   BITS         = 8,
    parameter logic FILL_BIT     = 1'b1,
    parameter int   SYNC_STAGES  = 2,
    parameter int   TURBO_FRAMES = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_PORTS*BITS-1:0] buttons_i,
    input  logic [NUM_PORTS*BITS-1:0] turbo_en_i,
    input  logic                      jp_latch_i,
    input  logic                      jp_clk_i,
    output logic [NUM_PORTS-1:0]      jp_data_o,
    output logic                      latch_strobe_o,
    output logic [7:0]                shift_cnt_o
);

    localparam int TCW = (TURBO_FRAMES > 1) ? $clog2(TURBO_FRAMES) : 1;
    localparam logic [TCW-1:0] TURBO_LAST = TCW'(TURBO_FRAMES - 1);

    logic [SYNC_STAGES-1:0] latch_sync;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic                   latch_s;
    logic                   clk_s;
    logic                   latch_prev;
    logic                   clk_prev;
    logic                   latch_fall;
    logic                   clk_rise;
    logic [TCW-1:0]         turbo_cnt;
    logic                   turbo_phase;
    logic [BITS-1:0]        shreg [NUM_PORTS];
    logic [BITS-1:0]        eff   [NUM_PORTS];

    // The clock chain idles high so leaving reset never fabricates a rising edge.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours, which a synchroniser chain relies on.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            latch_sync <= '0;
            clk_sync   <= '1;
            latch_prev <= 1'b0;
            clk_prev   <= 1'b1;
        end else begin
            latch_sync <= {latch_sync[SYNC_STAGES-2:0], jp_latch_i};
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], jp_clk_i};
            latch_prev <= latch_s;
            clk_prev   <= clk_s;
        end
    end

    assign latch_s    = latch_sync[SYNC_STAGES-1];
    assign clk_s      = clk_sync[SYNC_STAGES-1];
    assign latch_fall = latch_prev & ~latch_s;
    assign clk_rise   = clk_s & ~clk_prev;

    // NOTE: every variable written here is given a value on every path, so no
    // latch is inferred even if the loop bounds change.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            eff[p]       = buttons_i[p*BITS +: BITS]
                         & ~(turbo_en_i[p*BITS +: BITS] & {BITS{~turbo_phase}});
            jp_data_o[p] = shreg[p][0];
        end
    end

    // Load has priority over shift, so a clock edge during latch is swallowed.
    // NOTE: the shift-register array is reset explicitly because its bit 0 drives
    // the output pins; this is register storage, not a RAM.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int p = 0; p < NUM_PORTS; p++) shreg[p] <= '0;
            shift_cnt_o <= '0;
        end else if (latch_s) begin
            for (int p = 0; p < NUM_PORTS; p++) shreg[p] <= eff[p];
            shift_cnt_o <= '0;
        end else if (clk_rise) begin
            for (int p = 0; p < NUM_PORTS; p++) shreg[p] <= {FILL_BIT, shreg[p][BITS-1:1]};
            if (shift_cnt_o != 8'hFF) shift_cnt_o <= shift_cnt_o + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            latch_strobe_o <= 1'b0;
            turbo_cnt      <= '0;
            turbo_phase    <= 1'b1;
        end else begin
            latch_strobe_o <= latch_fall;
            if (latch_fall) begin
                if (turbo_cnt == TURBO_LAST) begin
                    turbo_cnt   <= '0;
                    turbo_phase <= ~turbo_phase;
                end else begin
                    turbo_cnt <= turbo_cnt + TCW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_joypad_serializer.sv
// Scoreboard bench: an 8-bit two-port instance (TURBO_FRAMES=2) and a 16-bit
// four-port instance; stimulus queues expected outputs, monitors pop and compare.
module tb_joypad_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i;

    logic [15:0] buttons_a, turbo_en_a;
    logic        latch_a, jclk_a;
    logic [1:0]  data_a;
    logic        strobe_a;
    logic [7:0]  cnt_a;

    logic [63:0] buttons_b, turbo_en_b;
    logic        latch_b, jclk_b;
    logic [3:0]  data_b;
    logic        strobe_b;
    logic [7:0]  cnt_b;

    joypad_serializer #(
        .NUM_PORTS(2), .BITS(8), .FILL_BIT(1'b1), .SYNC_STAGES(2), .TURBO_FRAMES(2)
    ) dut_a (
        .clk_i(clk), .rst_i(rst_i), .buttons_i(buttons_a), .turbo_en_i(turbo_en_a),
        .jp_latch_i(latch_a), .jp_clk_i(jclk_a), .jp_data_o(data_a),
        .latch_strobe_o(strobe_a), .shift_cnt_o(cnt_a)
    );

    joypad_serializer #(
        .NUM_PORTS(4), .BITS(16), .FILL_BIT(1'b1), .SYNC_STAGES(2), .TURBO_FRAMES(4)
    ) dut_b (
        .clk_i(clk), .rst_i(rst_i), .buttons_i(buttons_b), .turbo_en_i(turbo_en_b),
        .jp_latch_i(latch_b), .jp_clk_i(jclk_b), .jp_data_o(data_b),
        .latch_strobe_o(strobe_b), .shift_cnt_o(cnt_b)
    );

    typedef struct {
        bit         strobe;
        logic [3:0] data;
        logic [7:0] cnt;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [3:0] data, input logic [7:0] cnt);
        n_checks++;
        n_errors++;
        $display("FAIL %s: DUT output with nothing queued (data=0x%0h cnt=%0d t=%0t)",
                 name, data, cnt, $time);
    endtask

    task automatic cmp_item(input string tag, input exp_t e, input bit is_strobe,
                            input logic [3:0] data, input logic [7:0] cnt);
        check({tag, "_kind"}, 32'(is_strobe), 32'(e.strobe));
        check({tag, "_data"}, 32'(data), 32'(e.data));
        check({tag, "_cnt"},  32'(cnt),  32'(e.cnt));
    endtask

    // Monitors: an output event is a strobe pulse or a +1 step of shift_cnt_o.
    logic [7:0] prev_cnt_a = 8'd0;
    logic [7:0] prev_cnt_b = 8'd0;

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (!rst_i) begin
            if (strobe_a) begin
                if (q_a.size() == 0) unexpected("a_strobe", {2'b00, data_a}, cnt_a);
                else begin
                    e = q_a.pop_front();
                    cmp_item("a_strobe", e, 1'b1, {2'b00, data_a}, cnt_a);
                end
            end
            if ({1'b0, cnt_a} == {1'b0, prev_cnt_a} + 9'd1) begin
                if (q_a.size() == 0) unexpected("a_shift", {2'b00, data_a}, cnt_a);
                else begin
                    e = q_a.pop_front();
                    cmp_item("a_shift", e, 1'b0, {2'b00, data_a}, cnt_a);
                end
            end
        end
        prev_cnt_a = cnt_a;
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (!rst_i) begin
            if (strobe_b) begin
                if (q_b.size() == 0) unexpected("b_strobe", data_b, cnt_b);
                else begin
                    e = q_b.pop_front();
                    cmp_item("b_strobe", e, 1'b1, data_b, cnt_b);
                end
            end
            if ({1'b0, cnt_b} == {1'b0, prev_cnt_b} + 9'd1) begin
                if (q_b.size() == 0) unexpected("b_shift", data_b, cnt_b);
                else begin
                    e = q_b.pop_front();
                    cmp_item("b_shift", e, 1'b0, data_b, cnt_b);
                end
            end
        end
        prev_cnt_b = cnt_b;
    end

    // Stimulus helpers; sel=0 drives instance A, sel=1 drives instance B.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input bit sel, input bit s, input logic [3:0] d, input logic [7:0] c);
        exp_t e;
        e.strobe = s;
        e.data   = d;
        e.cnt    = c;
        if (sel) q_b.push_back(e);
        else     q_a.push_back(e);
    endtask

    task automatic set_latch(input bit sel, input logic v);
        if (sel) latch_b = v;
        else     latch_a = v;
    endtask

    task automatic set_jclk(input bit sel, input logic v);
        if (sel) jclk_b = v;
        else     jclk_a = v;
    endtask

    task automatic pulse(input bit sel);
        set_jclk(sel, 1'b0);
        tick(2);
        set_jclk(sel, 1'b1);
        tick(2);
    endtask

    task automatic latch_frame(input bit sel, input logic [3:0] first_data);
        set_latch(sel, 1'b1);
        tick(6);
        expect_out(sel, 1'b1, first_data, 8'd0);
        set_latch(sel, 1'b0);
        tick(4);
    endtask

    task automatic shift(input bit sel, input logic [3:0] d, input logic [7:0] c);
        expect_out(sel, 1'b0, d, c);
        pulse(sel);
    endtask

    // Bit seen on the pin after k shifts: word bit k, then the fill value.
    function automatic logic exp_bit(input logic [15:0] w, input int k, input int bits);
        if (k < bits) return w[k];
        return 1'b1;
    endfunction

    function automatic logic [3:0] exp_a(input logic [7:0] w0, input logic [7:0] w1, input int k);
        return {2'b00, exp_bit({8'h00, w1}, k, 8), exp_bit({8'h00, w0}, k, 8)};
    endfunction

    function automatic logic [3:0] exp_b(input int k);
        logic [3:0] r;
        r = '0;
        for (int p = 0; p < 4; p++) r[p] = exp_bit(buttons_b[p*16 +: 16], k, 16);
        return r;
    endfunction

    bit turbo_seq [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        rst_i      = 1'b1;
        latch_a    = 1'b0;  jclk_a = 1'b1;
        latch_b    = 1'b0;  jclk_b = 1'b1;
        buttons_a  = '0;    turbo_en_a = '0;
        buttons_b  = '0;    turbo_en_b = '0;

        // Reset with idle lines, then idle run.
        tick(3);
        check("rst_data_a",   32'(data_a),   32'd0);
        check("rst_cnt_a",    32'(cnt_a),    32'd0);
        check("rst_strobe_a", 32'(strobe_a), 32'd0);
        check("rst_data_b",   32'(data_b),   32'd0);
        rst_i = 1'b0;
        tick(10);
        check("idle_data_a",   32'(data_a),   32'd0);
        check("idle_cnt_a",    32'(cnt_a),    32'd0);
        check("idle_strobe_a", 32'(strobe_a), 32'd0);

        // Basic NES read with strobe timing two cycles after latch falls.
        buttons_a = {8'h3C, 8'hA5};
        latch_a = 1'b1;
        tick(6);
        expect_out(1'b0, 1'b1, exp_a(8'hA5, 8'h3C, 0), 8'd0);
        latch_a = 1'b0;
        tick(2);
        check("strobe_early",      32'(strobe_a), 32'd0);
        tick(1);
        check("strobe_on_time",    32'(strobe_a), 32'd1);
        tick(1);
        check("strobe_one_cycle",  32'(strobe_a), 32'd0);
        for (int k = 1; k <= 10; k++) shift(1'b0, exp_a(8'hA5, 8'h3C, k), 8'(k));
        tick(3);
        check("basic_cnt",  32'(cnt_a),  32'd10);
        check("basic_fill", 32'(data_a), 32'h3);

        // SNES width on the four-port instance.
        buttons_b = {16'h8001, 16'hFFFF, 16'h0000, 16'h1234};
        latch_frame(1'b1, exp_b(0));
        for (int k = 1; k <= 18; k++) shift(1'b1, exp_b(k), 8'(k));
        tick(3);
        check("snes_cnt",  32'(cnt_b),  32'd18);
        check("snes_fill", 32'(data_b), 32'hF);

        // Clock edge while latch is high: swallowed.
        latch_a = 1'b1;
        tick(3);
        pulse(1'b0);
        tick(4);
        check("collision_cnt",  32'(cnt_a),  32'd0);
        check("collision_data", 32'(data_a), 32'(exp_a(8'hA5, 8'h3C, 0)));
        expect_out(1'b0, 1'b1, exp_a(8'hA5, 8'h3C, 0), 8'd0);
        latch_a = 1'b0;
        tick(4);

        // Counter saturation.
        for (int k = 1; k <= 300; k++) begin
            if (k <= 255) expect_out(1'b0, 1'b0, exp_a(8'hA5, 8'h3C, k), 8'(k));
            pulse(1'b0);
        end
        tick(3);
        check("sat_cnt",  32'(cnt_a),  32'd255);
        check("sat_fill", 32'(data_a), 32'h3);

        // Return turbo state to reset values.
        rst_i = 1'b1;
        tick(2);
        rst_i = 1'b0;
        tick(2);
        check("rst2_cnt",  32'(cnt_a),  32'd0);
        check("rst2_data", 32'(data_a), 32'd0);

        // Turbo with two latch events per half-period.
        buttons_a  = {8'h00, 8'h01};
        turbo_en_a = {8'h00, 8'h01};
        for (int f = 0; f < 8; f++) begin
            latch_frame(1'b0, {3'b000, turbo_seq[f]});
            shift(1'b0, 4'h0, 8'd1);
            tick(2);
        end

        // Mid-frame reset; phase is 0 in frame C so port0 reads C3 & ~01 = C2.
        buttons_a  = {8'h5A, 8'hC3};
        turbo_en_a = {8'h00, 8'h01};
        latch_frame(1'b0, exp_a(8'hC3, 8'h5A, 0));
        latch_frame(1'b0, exp_a(8'hC3, 8'h5A, 0));
        latch_frame(1'b0, exp_a(8'hC2, 8'h5A, 0));
        for (int k = 1; k <= 3; k++) shift(1'b0, exp_a(8'hC2, 8'h5A, k), 8'(k));
        tick(3);
        rst_i = 1'b1;
        tick(1);
        check("midrst_data",   32'(data_a),   32'd0);
        check("midrst_cnt",    32'(cnt_a),    32'd0);
        check("midrst_strobe", 32'(strobe_a), 32'd0);
        rst_i = 1'b0;
        tick(2);
        latch_frame(1'b0, exp_a(8'hC3, 8'h5A, 0));
        for (int k = 1; k <= 9; k++) shift(1'b0, exp_a(8'hC3, 8'h5A, k), 8'(k));
        tick(3);
        check("post_rst_cnt",  32'(cnt_a),  32'd9);
        check("post_rst_fill", 32'(data_a), 32'h3);

        tick(5);
        check("queue_a_drained", 32'(q_a.size()), 32'd0);
        check("queue_b_drained", 32'(q_b.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/joypad_serializer.md
# joypad_serializer

Parametrised controller-port emulator: presents NUM_PORTS serial joypads to the NES core's latch/clock/data interface, with button state supplied as parallel words from the SoC GPIO. It generalises the fixed two-port 8-bit shifter to any port count and shift length (8 for NES, 16 for SNES-style pads), and adds input synchronisers, per-button turbo (autofire) and a frame strobe with a shift counter for software. It sits in `top` between the `fpga_top` GPIO outputs and the `nes_top` joypad pins.

## Interface

- NUM_PORTS, 2, number of emulated controllers
- BITS, 8, shift length per port (≥2)
- FILL_BIT, 1'b1, value shifted into the MSB on each shift
- SYNC_STAGES, 2, synchroniser depth on jp_latch_i / jp_clk_i (≥2)
- TURBO_FRAMES, 4, latch events per turbo half-period (≥1)

- clk_i  in  1  system clock, single domain
- rst_i  in  1  synchronous active-high reset
- buttons_i  in  NUM_PORTS*BITS  port p at [p*BITS +: BITS]; bit 0 shifted out first; 1 = pressed
- turbo_en_i  in  NUM_PORTS*BITS  per-button autofire enable, same packing
- jp_latch_i  in  1  latch from NES core, asynchronous, active high
- jp_clk_i  in  1  shift clock from NES core, asynchronous, shift on rising edge
- jp_data_o  out  NUM_PORTS  serial data, bit p = shift register p bit 0
- latch_strobe_o  out  1  one-cycle pulse on synchronised latch falling edge
- shift_cnt_o  out  8  rising jp_clk edges since last latch, saturating

## Operation

- Synchronisers: latch chain resets to 0, clock chain resets to 1 (idle-high line yields no edge at reset exit). latch_s / clk_s = last stage. clk_prev register (reset 1), latch_prev (reset 0).
- Effective word per port: eff = buttons_i & ~(turbo_en_i & {BITS{~turbo_phase}}). turbo_phase resets to 1 (all buttons pass).
- latch_s high: every cycle shift register p <= eff_p (level-sensitive, continuously reloaded); shift_cnt_o <= 0.
- latch_s low and clk_s & ~clk_prev: every register <= {FILL_BIT, reg[BITS-1:1]}; shift_cnt_o <= min(shift_cnt_o+1, 255).
- Latch high and clock edge in same cycle: load wins, no shift, count stays 0.
- After BITS shifts, jp_data_o = FILL_BIT indefinitely until next latch.
- Falling edge of latch_s (latch_prev & ~latch_s): latch_strobe_o = 1 for that cycle; turbo frame counter increments; when counter reaches TURBO_FRAMES-1 it wraps to 0 and turbo_phase toggles.
- Changes on buttons_i / turbo_en_i while latch_s low have no effect until next latch.
- rst_i mid-frame: all state to reset values next edge, regardless of latch/clock.

## Timing

- Reset values: shift registers 0, jp_data_o 0, shift_cnt_o 0, latch_strobe_o 0, turbo counter 0, turbo_phase 1.
- Input sampled high at edge k: synchronised value at edge k+SYNC_STAGES-1; register update (load/shift/strobe) at edge k+SYNC_STAGES; jp_data_o reflects it from then. Default: 2-cycle latency from first sampling edge.
- jp_data_o is registered (direct from shift bit 0); no combinational path from any input.
- Inputs pulses shorter than 2 clk_i periods may be missed; NES core pulses at 25 MHz domain are ≥4 clk_i cycles at 100 MHz.
- Throughput: one shift per synchronised rising edge; clock high/low each ≥1 cycle after sync.

## Test plan

- Reset: assert rst_i 3 cycles with jp_clk_i=1, jp_latch_i=0 → jp_data_o=00, shift_cnt_o=0, no strobe; release, hold idle 10 cycles → no shift, cnt 0.
- Basic NES read: buttons_i port0=8'hA5, port1=8'h3C; latch pulse 6 cycles, then 8 clock pulses → jp_data_o[0] sequence 1,0,1,0,0,1,0,1 and [1] 0,0,1,1,1,1,0,0; 9th+10th shift → both 1; shift_cnt_o=10; one latch_strobe_o pulse 2 cycles after latch falls.
- SNES width: BITS=16, NUM_PORTS=4, port3=16'h8001 → first bit 1, bits 2–15 = 0, 16th bit 1, then FILL_BIT; other ports independent.
- Turbo: TURBO_FRAMES=2, buttons 8'h01, turbo_en 8'h01, repeat 8 latch/read frames → bit0 first-read values 1,1,0,0,1,1,0,0.
- Collision and saturation: clock edge arriving while latch high → no shift, cnt 0; 300 clock edges after one latch → shift_cnt_o stays 255, data = FILL_BIT.
- Mid-frame reset: assert rst_i after 3 shifts → next cycle jp_data_o=0, cnt 0, turbo_phase 1; subsequent latch/read returns full word correctly.
